// File: rtl/izhikevich_neuron_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : izhikevich_neuron_array
//  Description : N Izhikevich neurons time-multiplexed over one saturating
//                fixed-point Euler-step datapath, with start/done handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module izhikevich_neuron_array #(
    parameter int                      N_NEURONS = 4,
    parameter int                      WIDTH     = 32,
    parameter int                      FRAC      = 16,
    parameter logic signed [WIDTH-1:0] A_P       = 1311,
    parameter logic signed [WIDTH-1:0] B_P       = 13107,
    parameter logic signed [WIDTH-1:0] C_P       = -4259840,
    parameter logic signed [WIDTH-1:0] D_P       = 524288,
    parameter logic signed [WIDTH-1:0] THRESH    = 1966080,
    parameter int                      DT_SHIFT  = 0,
    localparam int                     c_IDX_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int                     c_CNT_W   = $clog2(N_NEURONS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [N_NEURONS*WIDTH-1:0]    cur_flat,
    output logic                          busy,
    output logic                          done,
    output logic [N_NEURONS-1:0]          spike_vec,
    output logic [c_CNT_W-1:0]            spike_cnt,
    input  logic [c_IDX_W-1:0]            rd_idx,
    output logic signed [WIDTH-1:0]       rd_v,
    output logic signed [WIDTH-1:0]       rd_u
);

    typedef logic signed [2*WIDTH-1:0] wide_t;

    localparam wide_t                   c_K004 = wide_t'(((longint'(1) <<< FRAC) * 4 + 50) / 100);
    localparam wide_t                   c_K5   = wide_t'(5) <<< FRAC;
    localparam wide_t                   c_K140 = wide_t'(140) <<< FRAC;
    localparam logic signed [WIDTH-1:0] c_VMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] c_VMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] c_U0   = WIDTH'((wide_t'(B_P) * wide_t'(C_P)) >>> FRAC);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic                          w_accept;
    logic                          w_last;
    logic [c_IDX_W-1:0]            r_idx;
    logic [N_NEURONS*WIDTH-1:0]    r_cur;
    logic signed [WIDTH-1:0]       r_v [N_NEURONS];
    logic signed [WIDTH-1:0]       r_u [N_NEURONS];
    logic [N_NEURONS-1:0]          r_spk;
    logic [N_NEURONS-1:0]          w_spk_all;
    logic [c_CNT_W-1:0]            w_cnt;

    wide_t                         w_vw, w_uw, w_iw, w_vsq, w_dv, w_du;
    logic signed [WIDTH-1:0]       w_vn, w_un, w_v_upd, w_u_upd;
    logic                          w_spk;

    // Clamp is taken on the full double-width sum so a huge dv can never wrap.
    function automatic logic signed [WIDTH-1:0] sat(input wide_t x);
        if (x > wide_t'(c_VMAX)) begin
            sat = c_VMAX;
        end else if (x < wide_t'(c_VMIN)) begin
            sat = c_VMIN;
        end else begin
            sat = x[WIDTH-1:0];
        end
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (int'(r_idx) == N_NEURONS - 1) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        w_vw    = wide_t'(r_v[r_idx]);
        w_uw    = wide_t'(r_u[r_idx]);
        w_iw    = wide_t'($signed(r_cur[int'(r_idx)*WIDTH +: WIDTH]));
        w_vsq   = (w_vw * w_vw) >>> FRAC;
        w_dv    = ((c_K004 * w_vsq) >>> FRAC) + ((c_K5 * w_vw) >>> FRAC) + c_K140 - w_uw + w_iw;
        w_du    = (wide_t'(A_P) * (((wide_t'(B_P) * w_vw) >>> FRAC) - w_uw)) >>> FRAC;
        w_vn    = sat(w_vw + (w_dv >>> DT_SHIFT));
        w_un    = sat(w_uw + (w_du >>> DT_SHIFT));
        w_spk   = (w_vn >= THRESH);
        w_v_upd = w_spk ? C_P : w_vn;
        w_u_upd = w_spk ? sat(wide_t'(w_un) + wide_t'(D_P)) : w_un;
    end

    // Final spike vector includes the neuron being written on the last edge.
    always_comb begin
        w_spk_all        = r_spk;
        w_spk_all[r_idx] = w_spk;
        w_cnt            = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            w_cnt = w_cnt + c_CNT_W'(w_spk_all[i]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cur     <= '0;
            r_spk     <= '0;
            done      <= 1'b0;
            spike_vec <= '0;
            spike_cnt <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                r_v[i] <= C_P;
                r_u[i] <= c_U0;
            end
        end else begin
            r_state <= w_state_nxt;
            done    <= 1'b0;
            if (w_accept) begin
                r_cur <= cur_flat;
                r_idx <= '0;
            end else if (r_state == S_RUN) begin
                r_v[r_idx]   <= w_v_upd;
                r_u[r_idx]   <= w_u_upd;
                r_spk[r_idx] <= w_spk;
                if (w_last) begin
                    r_idx     <= '0;
                    done      <= 1'b1;
                    spike_vec <= w_spk_all;
                    spike_cnt <= w_cnt;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign busy = (r_state == S_RUN);
    assign rd_v = (int'(rd_idx) < N_NEURONS) ? r_v[rd_idx] : '0;
    assign rd_u = (int'(rd_idx) < N_NEURONS) ? r_u[rd_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_izhikevich_neuron_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_izhikevich_neuron_array
//  Description : Scoreboard bench for izhikevich_neuron_array, two instances
//                (dt = 1 and dt = 1/4) against a longint arithmetic model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_izhikevich_neuron_array;

    localparam int     N    = 4;
    localparam int     W    = 32;
    localparam int     NI   = 2;
    localparam longint CV   = -4259840;
    localparam longint U0   = -851955;
    localparam longint TH   = 1966080;
    localparam longint DP   = 524288;
    localparam longint VMAX = 64'sd2147483647;
    localparam longint VMIN = -64'sd2147483648;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [N*W-1:0]   cur_flat;
    logic [1:0]       rd_idx;
    logic             busy      [NI];
    logic             done      [NI];
    logic [N-1:0]     spike_vec [NI];
    logic [2:0]       spike_cnt [NI];
    logic [W-1:0]     rd_v      [NI];
    logic [W-1:0]     rd_u      [NI];

    always #10 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        izhikevich_neuron_array #(
            .N_NEURONS (N),
            .WIDTH     (W),
            .DT_SHIFT  (2*k)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .start     (start),
            .cur_flat  (cur_flat),
            .busy      (busy[k]),
            .done      (done[k]),
            .spike_vec (spike_vec[k]),
            .spike_cnt (spike_cnt[k]),
            .rd_idx    (rd_idx),
            .rd_v      (rd_v[k]),
            .rd_u      (rd_u[k])
        );
    end

    typedef struct packed {
        logic                           snap;
        int                             due;
        logic [NI-1:0][N-1:0]           sv;
        logic [NI-1:0][N-1:0][W-1:0]    v;
        logic [NI-1:0][N-1:0][W-1:0]    u;
    } exp_t;

    exp_t         q[$];
    longint       mv [NI][N];
    longint       mu [NI][N];
    logic [N-1:0] mspk [NI];
    int           cyc = 0;
    int           nchk = 0;
    int           nfail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint clamp(input longint x);
        if (x > VMAX) return VMAX;
        if (x < VMIN) return VMIN;
        return x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            mspk[k] = '0;
            for (int i = 0; i < N; i++) begin
                mv[k][i] = CV;
                mu[k][i] = U0;
            end
        end
    endtask

    // One Euler step of every neuron, straight from the Q16.16 equations.
    task automatic model_step(input logic [N*W-1:0] c);
        longint v, u, cur, vsq, dv, du, vn, un;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < N; i++) begin
                v   = mv[k][i];
                u   = mu[k][i];
                cur = longint'($signed(c[i*W +: W]));
                vsq = (v * v) >>> 16;
                dv  = ((2621 * vsq) >>> 16) + 5 * v + 140 * 65536 - u + cur;
                du  = (1311 * (((13107 * v) >>> 16) - u)) >>> 16;
                vn  = clamp(v + (dv >>> (2*k)));
                un  = clamp(u + (du >>> (2*k)));
                if (vn >= TH) begin
                    mv[k][i]   = CV;
                    mu[k][i]   = clamp(un + DP);
                    mspk[k][i] = 1'b1;
                end else begin
                    mv[k][i]   = vn;
                    mu[k][i]   = un;
                    mspk[k][i] = 1'b0;
                end
            end
        end
    endtask

    function automatic exp_t make_item(input logic snap, input int due);
        exp_t e;
        e.snap = snap;
        e.due  = due;
        for (int k = 0; k < NI; k++) begin
            e.sv[k] = mspk[k];
            for (int i = 0; i < N; i++) begin
                e.v[k][i] = 32'(mv[k][i]);
                e.u[k][i] = 32'(mu[k][i]);
            end
        end
        return e;
    endfunction

    task automatic chk(input string nm, input int k, input int i,
                       input logic [63:0] act, input logic [63:0] expv);
        nchk++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s dut=%0d idx=%0d actual=0x%0h expected=0x%0h t=%0t",
                     nm, k, i, act, expv, $time);
        end
    endtask

    // ---------------- monitor ----------------
    task automatic check_item(input exp_t e, input bit at_done);
        for (int k = 0; k < NI; k++) begin
            if (at_done) chk("latency", k, 0, 64'(cyc), 64'(e.due));
            chk("busy_idle", k, 0, 64'(busy[k]), 64'(0));
            chk("spike_vec", k, 0, 64'(spike_vec[k]), 64'(e.sv[k]));
            chk("spike_cnt", k, 0, 64'(spike_cnt[k]), 64'($countones(e.sv[k])));
        end
        for (int i = 0; i < N; i++) begin
            rd_idx = 2'(i);
            #1;
            for (int k = 0; k < NI; k++) begin
                chk("rd_v", k, i, 64'(rd_v[k]), 64'(e.v[k][i]));
                chk("rd_u", k, i, 64'(rd_u[k]), 64'(e.u[k][i]));
            end
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (done[0] || done[1]) begin
                chk("done_pair", 1, 0, 64'(done[1]), 64'(done[0]));
                if (q.size() == 0 || q[0].snap) begin
                    nchk++;
                    nfail++;
                    $display("FAIL unexpected_done actual=1 expected=0 t=%0t", $time);
                end else begin
                    e = q.pop_front();
                    check_item(e, 1'b1);
                end
            end else if (q.size() > 0 && q[0].snap) begin
                e = q.pop_front();
                check_item(e, 1'b0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_snap();
        @(posedge clk);
        #2;
        q.push_back(make_item(1'b1, 0));
        @(negedge clk);
        @(negedge clk);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [N*W-1:0] c);
        cur_flat = c;
        start    = 1'b1;
        model_step(c);
        q.push_back(make_item(1'b0, cyc + 1 + N));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        nchk++;
        for (int t = 0; t < 4*N; t++) begin
            @(negedge clk);
            if (done[0]) return;
        end
        nfail++;
        $display("FAIL done_timeout actual=0 expected=1 t=%0t", $time);
    endtask

    task automatic step(input logic [N*W-1:0] c);
        issue(c);
        wait_done();
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [N*W-1:0] c;
        c[0*W +: W] = c0;
        c[1*W +: W] = c1;
        c[2*W +: W] = c2;
        c[3*W +: W] = c3;
        return c;
    endfunction

    function automatic int rand_cur();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return int'($urandom);
        if (r == 1) return int'($urandom_range(0, 1200)) <<< 16;
        return int'($urandom_range(0, 40 << 16)) - (10 << 16);
    endfunction

    initial begin
        logic [N*W-1:0] c;
        reset    = 1'b1;
        start    = 1'b0;
        cur_flat = '0;
        rd_idx   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        push_snap();

        step(pack4(1000 << 16, 1000 << 16, 1000 << 16, 1000 << 16));
        step(pack4(0, 1000 << 16, 0, 1000 << 16));
        repeat (3) step(pack4(-32'sh40000000, 0, 0, 0));

        // start pulse while busy, with different currents on the bus
        issue(pack4(5 << 16, 10 << 16, 15 << 16, 20 << 16));
        cur_flat = pack4(1000 << 16, 1000 << 16, 1000 << 16, 1000 << 16);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);

        // start in the same cycle as done
        issue(pack4(3 << 16, 0, 7 << 16, 1 << 16));
        wait_done();
        issue(pack4(2 << 16, 4 << 16, 6 << 16, 8 << 16));
        for (int k = 0; k < NI; k++) chk("busy_after_done_start", k, 0, 64'(busy[k]), 64'(1));
        wait_done();
        @(negedge clk);

        // reset two cycles into a step; the step is never expected to finish
        cur_flat = pack4(1000 << 16, 1000 << 16, 1000 << 16, 1000 << 16);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("busy_in_reset", k, 0, 64'(busy[k]), 64'(0));
            chk("done_in_reset", k, 0, 64'(done[k]), 64'(0));
            chk("spike_in_reset", k, 0, 64'(spike_vec[k]), 64'(0));
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_snap();

        for (int s = 0; s < 500; s++) begin
            for (int i = 0; i < N; i++) c[i*W +: W] = rand_cur();
            step(c);
        end

        @(negedge clk);
        chk("queue_drained", 0, 0, 64'(q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
`default_nettype wire
